// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester-side and UART-side signals of the shared transmitter arbiter.
interface uart_tx_arb_if #(parameter int NREQ = 4);
  logic [NREQ-1:0] req, gnt, ack, err;
  logic [8*NREQ-1:0] req_data;
  logic busy, tx_start, tx_done, tx_err;
  logic [7:0] tx_data;
  modport master (output req, req_data, tx_done, tx_err, input gnt, ack, err, busy, tx_start, tx_data);
  modport slave (input req, req_data, tx_done, tx_err, output gnt, ack, err, busy, tx_start, tx_data);
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART transmitter among NREQ requesters.
// Define UART_ARB_TIMEOUT_EN to add a WAIT watchdog that ends a frame after TIMEOUT_CYCLES clocks.
module uart_tx_arb #(
  parameter int NREQ = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic clk,
  input logic rst_n,
  uart_tx_arb_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [2:0] {IDLE, GRANT, START, WAIT, DONE} state_t;
  state_t state;
  logic [IW-1:0] ptr, win, nxt;
  logic [IW:0] s;
  logic flag;
`ifdef UART_ARB_TIMEOUT_EN
  logic [17:0] tmr;
`endif
  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2**18) begin : g_bad_param
    $error("uart_tx_arb: parameter out of range");
  end
  // walk downwards so the request closest to ptr (after wrap) is assigned last and wins
  always_comb begin
    nxt = '0;
    s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (IW+1)'(i);
      s = (s >= (IW+1)'(NREQ)) ? s - (IW+1)'(NREQ) : s;
      if (bus.req[s[IW-1:0]]) nxt = s[IW-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      flag <= 1'b0;
      bus.gnt <= '0;
      bus.ack <= '0;
      bus.err <= '0;
      bus.busy <= 1'b0;
      bus.tx_start <= 1'b0;
      bus.tx_data <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
      tmr <= '0;
`endif
    end else begin
      bus.ack <= '0;
      bus.err <= '0;
      bus.tx_start <= 1'b0;
      case (state)
        IDLE: if (|bus.req) begin
          state <= GRANT;
          win <= nxt;
          bus.gnt <= NREQ'(1) << nxt;
          bus.tx_data <= bus.req_data[8*nxt +: 8];
          bus.busy <= 1'b1;
          flag <= 1'b0;
        end
        GRANT: begin
          state <= START;
          bus.tx_start <= 1'b1;
        end
        START: begin
          state <= WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          tmr <= '0;
`endif
        end
        WAIT: begin
          flag <= flag | bus.tx_err;
          if (bus.tx_done) begin
            state <= DONE;
            bus.ack <= bus.gnt;
            bus.err <= (flag | bus.tx_err) ? bus.gnt : '0;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (tmr == 18'(TIMEOUT_CYCLES - 1)) begin
            state <= DONE;
            bus.ack <= bus.gnt;
            bus.err <= bus.gnt;
          end else tmr <= tmr + 18'd1;
`endif
        end
        DONE: begin
          state <= IDLE;
          bus.gnt <= '0;
          bus.busy <= 1'b0;
          ptr <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed and randomized checks of uart_tx_arb against a round-robin reference model.
module tb_uart_tx_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  int m_ptr = 0;
  logic [7:0] bd [4];
  uart_tx_arb_if #(.NREQ(4)) bus();
  uart_tx_arb #(.NREQ(4), .TIMEOUT_CYCLES(50)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always_comb bus.req_data = {bd[3], bd[2], bd[1], bd[0]};

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return 0;
  endfunction

  // drives one transfer from IDLE to the IDLE cycle after DONE and reports what the DUT showed
  task automatic xfer(input int dly, input int err_at, input logic noise, input logic [3:0] drop,
                      input logic [3:0] arrive, input logic hold,
                      output logic [3:0] g, output logic [7:0] d, output int lat, output int starts,
                      output logic st_ok, output logic stable, output logic [3:0] a, output logic [3:0] e,
                      output logic [3:0] after_g, output logic after_busy, output logic [3:0] after_ack);
    lat = 0;
    while (bus.gnt === 4'b0 && lat < 10) begin @(negedge clk); lat++; end
    g = bus.gnt;
    d = bus.tx_data;
    starts = int'(bus.tx_start);
    stable = 1'b1;
    bus.tx_done = noise;
    bus.tx_err = noise;
    @(negedge clk);
    st_ok = bus.tx_start;
    starts += int'(bus.tx_start);
    @(negedge clk);
    starts += int'(bus.tx_start);
    for (int c = 1; c <= dly; c++) begin
      bus.tx_done = (c == dly);
      bus.tx_err = (c == err_at);
      if (c == 1) bus.req = (bus.req & ~drop) | arrive;
      @(negedge clk);
      starts += int'(bus.tx_start);
      if (bus.gnt !== g || bus.tx_data !== d || (c < dly && bus.ack !== 4'b0)) stable = 1'b0;
    end
    a = bus.ack;
    e = bus.err;
    bus.tx_done = 1'b0;
    bus.tx_err = 1'b0;
    if (!hold) bus.req &= ~a;
    @(negedge clk);
    after_g = bus.gnt;
    after_busy = bus.busy;
    after_ack = bus.ack;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.tx_done = 1'b0;
    bus.tx_err = 1'b0;
    for (int i = 0; i < 4; i++) bd[i] = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.gnt, bus.ack, bus.err, bus.busy, bus.tx_start, bus.tx_data} !== 22'b0)
      $display("FAIL reset_outputs: got %h want 0", {bus.gnt, bus.ack, bus.err, bus.busy, bus.tx_start, bus.tx_data});
    else passed++;
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.gnt, bus.busy, bus.tx_start, bus.ack} !== 10'b0)
      $display("FAIL idle_after_reset: got %h want 0", {bus.gnt, bus.busy, bus.tx_start, bus.ack});
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] g, a, e, ag, aa;
    logic [7:0] d;
    logic sok, stb, ab;
    int lat, st, w;
    bd[0] = 8'h11; bd[1] = 8'h22; bd[2] = 8'h33; bd[3] = 8'h44;
    bus.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      w = pick(bus.req, m_ptr);
      xfer(3, 0, 1'b0, '0, '0, 1'b1, g, d, lat, st, sok, stb, a, e, ag, ab, aa);
      total++;
      if (g !== 4'(1 << w) || a !== g) $display("FAIL rr_grant %0d: got gnt %b ack %b want %b", k, g, a, 4'(1 << w));
      else passed++;
      total++;
      if (d !== bd[w]) $display("FAIL rr_data %0d: got %h want %h", k, d, bd[w]);
      else passed++;
      m_ptr = (w + 1) % 4;
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [3:0] g, a, e, ag, aa;
    logic [7:0] d;
    logic sok, stb, ab;
    int lat, st, w;
    bd[0] = 8'hAF;
    bus.req = 4'b0001;
    w = pick(bus.req, m_ptr);
    xfer(10, 0, 1'b0, '0, '0, 1'b0, g, d, lat, st, sok, stb, a, e, ag, ab, aa);
    total++; if (g !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", g); else passed++;
    total++; if (d !== 8'hAF) $display("FAIL single_data: got %h want af", d); else passed++;
    total++; if (st !== 1 || sok !== 1'b1) $display("FAIL single_start: got %0d strobes (on time %b) want 1", st, sok); else passed++;
    total++; if (lat !== 1) $display("FAIL single_latency: got %0d want 1", lat); else passed++;
    total++; if (a !== 4'b0001) $display("FAIL single_ack: got %b want 0001", a); else passed++;
    total++; if (e !== 4'b0000) $display("FAIL single_err: got %b want 0000", e); else passed++;
    total++; if ({ag, ab, aa} !== 9'b0) $display("FAIL single_idle_after: got %h want 0", {ag, ab, aa}); else passed++;
    total++; if (stb !== 1'b1) $display("FAIL single_stable: got %b want 1", stb); else passed++;
    m_ptr = (w + 1) % 4;
  endtask

  task automatic test_err();
    logic [3:0] g, a, e, ag, aa;
    logic [7:0] d;
    logic sok, stb, ab;
    int lat, st;
    bd[2] = 8'h5C;
    bus.req = 4'b0100;
    xfer(6, 3, 1'b0, '0, '0, 1'b0, g, d, lat, st, sok, stb, a, e, ag, ab, aa);
    total++; if (a !== 4'b0100) $display("FAIL err_ack: got %b want 0100", a); else passed++;
    total++; if (e !== 4'b0100) $display("FAIL err_flag: got %b want 0100", e); else passed++;
    bus.req = 4'b0100;
    xfer(4, 0, 1'b1, '0, '0, 1'b0, g, d, lat, st, sok, stb, a, e, ag, ab, aa);
    total++; if (a !== 4'b0100) $display("FAIL err_next_ack: got %b want 0100", a); else passed++;
    total++; if (e !== 4'b0000) $display("FAIL err_next_clear: got %b want 0000", e); else passed++;
    m_ptr = 3;
  endtask

  task automatic test_reset_mid();
    logic [3:0] g, a, e, ag, aa;
    logic [7:0] d;
    logic sok, stb, ab, seen;
    int lat, st, w, n;
    bd[1] = 8'h3E;
    bus.req = 4'b0010;
    n = 0;
    while (bus.gnt === 4'b0 && n < 10) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.gnt, bus.ack, bus.err, bus.busy, bus.tx_start, bus.tx_data} !== 22'b0)
      $display("FAIL async_reset: got %h want 0", {bus.gnt, bus.ack, bus.err, bus.busy, bus.tx_start, bus.tx_data});
    else passed++;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= |{bus.ack, bus.err, bus.gnt, bus.busy, bus.tx_start};
    end
    total++; if (seen !== 1'b0) $display("FAIL reset_no_ack: got %b want 0", seen); else passed++;
    bd[3] = 8'hC7;
    bus.req = 4'b1010;
    rst_n = 1'b1;
    m_ptr = 0;
    w = pick(bus.req, m_ptr);
    xfer(2, 0, 1'b0, '0, '0, 1'b0, g, d, lat, st, sok, stb, a, e, ag, ab, aa);
    total++; if (g !== 4'(1 << w) || a !== g) $display("FAIL reset_regrant: got gnt %b ack %b want %b", g, a, 4'(1 << w)); else passed++;
    total++; if (d !== bd[w]) $display("FAIL reset_regrant_data: got %h want %h", d, bd[w]); else passed++;
    m_ptr = (w + 1) % 4;
  endtask

  task automatic test_drop();
    logic [3:0] g, a, e, ag, aa;
    logic [7:0] d;
    logic sok, stb, ab;
    int lat, st, w;
    w = pick(bus.req, m_ptr);
    xfer(5, 0, 1'b0, 4'b1000, '0, 1'b0, g, d, lat, st, sok, stb, a, e, ag, ab, aa);
    total++; if (g !== 4'b1000 || w != 3) $display("FAIL drop_gnt: got %b want 1000", g); else passed++;
    total++; if (a !== 4'b1000 || stb !== 1'b1) $display("FAIL drop_ack: got %b (stable %b) want 1000", a, stb); else passed++;
    m_ptr = (w + 1) % 4;
    bd[0] = 8'h01;
    bus.req = 4'b1001;
    w = pick(bus.req, m_ptr);
    xfer(2, 0, 1'b0, '0, '0, 1'b0, g, d, lat, st, sok, stb, a, e, ag, ab, aa);
    total++; if (g !== 4'(1 << w)) $display("FAIL drop_ptr_wrap: got %b want %b", g, 4'(1 << w)); else passed++;
    m_ptr = (w + 1) % 4;
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] g, a, e, ag, aa, add, arr, drp, wm;
    logic [7:0] d, xd;
    logic sok, stb, ab, nz;
    logic [6:0] fl;
    int lat, st, w, dly, ea;
    for (int k = 0; k < 25; k++) begin
      add = 4'($urandom_range(0, 15)) & ~bus.req;
      if ((bus.req | add) == 4'b0) add = 4'b0001 << $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) if (add[i]) bd[i] = 8'($urandom);
      bus.req |= add;
      w = pick(bus.req, m_ptr);
      wm = 4'(1 << w);
      xd = bd[w];
      dly = int'($urandom_range(1, 6));
      ea = int'($urandom_range(0, dly));
      nz = 1'($urandom);
      drp = $urandom_range(0, 1) ? wm : 4'b0;
      arr = 4'($urandom_range(0, 15)) & ~bus.req;
      for (int i = 0; i < 4; i++) if (arr[i]) bd[i] = 8'($urandom);
      xfer(dly, ea, nz, drp, arr, 1'b0, g, d, lat, st, sok, stb, a, e, ag, ab, aa);
      total++;
      if ({g, d, a, e} !== {wm, xd, wm, (ea != 0) ? wm : 4'b0})
        $display("FAIL rand_xfer %0d: got gnt %b data %h ack %b err %b want %b %h %b %b",
                 k, g, d, a, e, wm, xd, wm, (ea != 0) ? wm : 4'b0);
      else passed++;
      fl = {st == 1, lat == 1, sok, stb, ag == 4'b0, ~ab, aa == 4'b0};
      total++;
      if (fl !== 7'h7F) $display("FAIL rand_timing %0d: got flags %b want 1111111", k, fl);
      else passed++;
      m_ptr = (w + 1) % 4;
    end
    bus.req = '0;
    @(negedge clk);
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] g;
    int n, w;
    for (int r = 0; r < 2; r++) begin
      bus.req = 4'b0001;
      w = pick(bus.req, m_ptr);
      n = 0;
      while (bus.gnt === 4'b0 && n < 10) begin @(negedge clk); n++; end
      g = bus.gnt;
      @(negedge clk);
      n = 0;
      while (bus.ack === 4'b0 && n < 200) begin
        bus.tx_done = (r == 1 && n == 50);
        @(negedge clk);
        n++;
      end
      bus.tx_done = 1'b0;
      total++; if (n != 51) $display("FAIL timeout_cycles %0d: got %0d want 51", r, n); else passed++;
      total++; if (bus.ack !== 4'(1 << w) || g !== 4'(1 << w)) $display("FAIL timeout_ack %0d: got %b want %b", r, bus.ack, 4'(1 << w)); else passed++;
      total++; if (bus.err !== ((r == 0) ? 4'(1 << w) : 4'b0)) $display("FAIL timeout_err %0d: got %b want %b", r, bus.err, (r == 0) ? 4'(1 << w) : 4'b0); else passed++;
      bus.req = '0;
      @(negedge clk);
      total++; if ({bus.busy, bus.gnt} !== 5'b0) $display("FAIL timeout_idle %0d: got %b want 0", r, {bus.busy, bus.gnt}); else passed++;
      m_ptr = (w + 1) % 4;
    end
  endtask
`else
  task automatic test_no_timeout();
    logic [3:0] g;
    int n, w, acks;
    bus.req = 4'b0001;
    w = pick(bus.req, m_ptr);
    n = 0;
    while (bus.gnt === 4'b0 && n < 10) begin @(negedge clk); n++; end
    g = bus.gnt;
    @(negedge clk);
    acks = 0;
    repeat (120) begin @(negedge clk); acks += int'(|bus.ack); end
    total++; if (acks != 0 || bus.busy !== 1'b1) $display("FAIL no_timeout_wait: got %0d acks busy %b want 0 acks busy 1", acks, bus.busy); else passed++;
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    total++; if (bus.ack !== 4'(1 << w) || g !== 4'(1 << w) || bus.err !== 4'b0) $display("FAIL no_timeout_done: got ack %b err %b want %b 0000", bus.ack, bus.err, 4'(1 << w)); else passed++;
    bus.req = '0;
    @(negedge clk);
    m_ptr = (w + 1) % 4;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_err();
    test_reset_mid();
    test_drop();
    test_random();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, total);
    $fatal(1);
  end
endmodule
